lcd_frame_collector: RTL and testbench

LCD_FRAME_COLLECTOR -- requirements
Module: lcd_frame_collector

---
 rtl/lcd_pkg.sv | 24 ++
 rtl/lcd_frame_stats.sv | 30 +++
 rtl/lcd_frame_collector.sv | 124 ++++++++++++
 tb/tb_lcd_frame_collector.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD frame collector slice.
// Covers pixel geometry, the collector state encoding and the LCD controller command codes.
package lcd_pkg;

  localparam int PIX_W     = 8;
  localparam int FRAME_PIX = 16;
  localparam int SUM_W     = 12;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD,
    DROP
  } state_t;

  // Command codes understood by the upstream LCD controller.
  localparam logic [7:0] LCD_CMD_CLEAR     = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME      = 8'h02;
  localparam logic [7:0] LCD_CMD_ENTRY     = 8'h06;
  localparam logic [7:0] LCD_CMD_DISP_ON   = 8'h0C;
  localparam logic [7:0] LCD_CMD_FUNC_SET  = 8'h38;
  localparam logic [7:0] LCD_CMD_SET_DDRAM = 8'h80;

endpackage

// File: rtl/lcd_frame_stats.sv
// Running sum / maximum accumulator for one frame of pixels.
// When clear and accumulate are both high, the pixel seeds a fresh frame.
module lcd_frame_stats
  import lcd_pkg::*;
#(
  parameter int PIX_W = lcd_pkg::PIX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             accumulate,
  input  logic [PIX_W-1:0] pixel,
  output logic [SUM_W-1:0] sum,
  output logic [PIX_W-1:0] max_pix
);

  always_ff @(posedge clk) begin
    if (reset) begin
      sum     <= '0;
      max_pix <= '0;
    end else if (clear) begin
      sum     <= accumulate ? SUM_W'(pixel) : '0;
      max_pix <= accumulate ? pixel : '0;
    end else if (accumulate) begin
      sum <= sum + SUM_W'(pixel);
      if (pixel > max_pix) max_pix <= pixel;
    end
  end

endmodule

// File: rtl/lcd_frame_collector.sv
// Collects 16-pixel bursts from the LCD controller into a frame buffer and holds
// each complete frame, with its sum and max, until the consumer releases it.
module lcd_frame_collector
  import lcd_pkg::*;
#(
  parameter int PIX_W     = lcd_pkg::PIX_W,
  parameter int FRAME_PIX = lcd_pkg::FRAME_PIX
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PIX_W-1:0] datain,
  input  logic             in_valid,
  output logic             frame_valid,
  input  logic             frame_ready,
  input  logic [3:0]       rd_addr,
  output logic [PIX_W-1:0] rd_data,
  output logic [11:0]      frame_sum,
  output logic [PIX_W-1:0] frame_max,
  output logic [7:0]       frame_cnt,
  output logic             err_short,
  output logic             err_overrun
);

  localparam int IDX_W = $clog2(FRAME_PIX);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_PIX - 1);

  state_t           state, state_next;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] waddr;
  logic             accept_first, accept_next, frame_done;
  logic             release_frame, short_err, overrun, buf_we;
  logic [PIX_W-1:0] pix_buf [FRAME_PIX];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // DROP returns to HOLD only if the frame survived the burst unreleased.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = COLLECT;
      COLLECT: begin
        if (!in_valid)             state_next = IDLE;
        else if (idx == LAST_IDX)  state_next = HOLD;
      end
      HOLD: begin
        if (frame_ready)   state_next = in_valid ? COLLECT : IDLE;
        else if (in_valid) state_next = DROP;
      end
      DROP:    if (!in_valid) state_next = (frame_valid && !frame_ready) ? HOLD : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    accept_first  = 1'b0;
    accept_next   = 1'b0;
    frame_done    = 1'b0;
    release_frame = 1'b0;
    short_err     = 1'b0;
    overrun       = 1'b0;
    case (state)
      IDLE:    accept_first = in_valid;
      COLLECT: begin
        accept_next = in_valid;
        frame_done  = in_valid && (idx == LAST_IDX);
        short_err   = !in_valid;
      end
      HOLD: begin
        release_frame = frame_ready;
        accept_first  = frame_ready && in_valid;
        overrun       = in_valid && !frame_ready;
      end
      DROP:    release_frame = frame_valid && frame_ready;
      default: ;
    endcase
    buf_we = accept_first || accept_next;
    waddr  = accept_first ? '0 : idx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx         <= '0;
      frame_valid <= 1'b0;
      frame_cnt   <= '0;
      err_short   <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      err_short   <= short_err;
      err_overrun <= overrun;
      if (accept_first)     idx <= IDX_W'(1);
      else if (accept_next) idx <= idx + IDX_W'(1);
      else if (short_err)   idx <= '0;
      if (frame_done)         frame_valid <= 1'b1;
      else if (release_frame) frame_valid <= 1'b0;
      if (release_frame) frame_cnt <= frame_cnt + 8'd1;
    end
  end

  // Buffer contents deliberately survive reset; only the read register clears.
  always_ff @(posedge clk) begin
    if (buf_we) pix_buf[waddr] <= datain;
  end

  always_ff @(posedge clk) begin
    if (reset) rd_data <= '0;
    else       rd_data <= pix_buf[rd_addr];
  end

  lcd_frame_stats #(
    .PIX_W(PIX_W)
  ) u_stats (
    .clk       (clk),
    .reset     (reset),
    .clear     (accept_first),
    .accumulate(buf_we),
    .pixel     (datain),
    .sum       (frame_sum),
    .max_pix   (frame_max)
  );

endmodule

// File: tb/tb_lcd_frame_collector.sv
// Self-checking bench: a queue-based frame model checked every cycle, plus
// literal expectations for the headline scenarios.
module tb_lcd_frame_collector;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  datain = '0;
  logic        in_valid = 1'b0;
  logic        frame_ready = 1'b0;
  logic [3:0]  rd_addr = '0;
  logic        frame_valid;
  logic [7:0]  rd_data;
  logic [11:0] frame_sum;
  logic [7:0]  frame_max;
  logic [7:0]  frame_cnt;
  logic        err_short;
  logic        err_overrun;

  int checks = 0;
  int errors = 0;

  lcd_frame_collector dut (
    .clk        (clk),
    .reset      (reset),
    .datain     (datain),
    .in_valid   (in_valid),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .frame_sum  (frame_sum),
    .frame_max  (frame_max),
    .frame_cnt  (frame_cnt),
    .err_short  (err_short),
    .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  // Model: expected outputs after the coming edge, derived from frame-level rules.
  logic [7:0]  mem [16];
  bit          mem_known [16];
  logic [7:0]  q [$];
  bit          collecting, held, dropping, model_on;
  logic [7:0]  m_cnt, exp_max, exp_rd;
  logic [11:0] exp_sum;
  bit          exp_short, exp_over, rd_known;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic startFrame(input logic [7:0] d);
    q.delete();
    q.push_back(d);
    mem[0] = d;
    mem_known[0] = 1'b1;
    collecting = 1'b1;
  endtask

  task automatic addPixel(input logic [7:0] d);
    int s;
    logic [7:0] m;
    mem[q.size()] = d;
    mem_known[q.size()] = 1'b1;
    q.push_back(d);
    if (q.size() == 16) begin
      s = 0;
      m = 0;
      foreach (q[i]) begin
        s += int'(q[i]);
        if (q[i] > m) m = q[i];
      end
      exp_sum = 12'(s);
      exp_max = m;
      held = 1'b1;
      collecting = 1'b0;
    end
  endtask

  task automatic modelStep();
    if (reset) begin
      collecting = 0; held = 0; dropping = 0; q.delete();
      m_cnt = 0; exp_sum = 0; exp_max = 0; exp_short = 0; exp_over = 0;
      exp_rd = 0; rd_known = 1;
      return;
    end
    exp_rd    = mem[rd_addr];
    rd_known  = mem_known[rd_addr];
    exp_short = 0;
    exp_over  = 0;
    if (dropping) begin
      if (frame_ready && held) begin held = 0; m_cnt++; end
      if (!in_valid) dropping = 0;
    end else if (held) begin
      if (frame_ready) begin
        held = 0;
        m_cnt++;
        if (in_valid) startFrame(datain);
      end else if (in_valid) begin
        dropping = 1;
        exp_over = 1;
      end
    end else if (collecting) begin
      if (in_valid) addPixel(datain);
      else begin
        collecting = 0;
        exp_short = 1;
        q.delete();
      end
    end else if (in_valid) begin
      startFrame(datain);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit v, input logic [7:0] d,
                               input bit rdy, input logic [3:0] a);
    @(negedge clk);
    reset = rst;
    in_valid = v;
    datain = d;
    frame_ready = rdy;
    rd_addr = a;
    modelStep();
    model_on = 1'b1;
  endtask

  task automatic burst(input int n, input logic [7:0] base, input logic [7:0] inc,
                       input bit rdy_first, input logic [3:0] a);
    for (int i = 0; i < n; i++)
      applyStimulus(0, 1, base + 8'(i) * inc, rdy_first && (i == 0), a);
  endtask

  task automatic idle(input int n, input logic [3:0] a);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 8'h00, 0, a);
  endtask

  // Every-cycle comparison against the model, just after the outputs settle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (model_on) begin
        checkOutput("frame_valid", 32'(frame_valid), 32'(held));
        checkOutput("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
        checkOutput("err_short", 32'(err_short), 32'(exp_short));
        checkOutput("err_overrun", 32'(err_overrun), 32'(exp_over));
        if (held) begin
          checkOutput("frame_sum", 32'(frame_sum), 32'(exp_sum));
          checkOutput("frame_max", 32'(frame_max), 32'(exp_max));
        end
        if (rd_known) checkOutput("rd_data", 32'(rd_data), 32'(exp_rd));
      end
    end
  end

  initial begin
    model_on = 0;
    foreach (mem_known[i]) mem_known[i] = 1'b0;
    applyStimulus(1, 0, 8'h00, 0, 4'd0);
    applyStimulus(1, 0, 8'h00, 0, 4'd0);
    idle(1, 4'd0);

    // Short burst of 10 pixels.
    burst(10, 8'd1, 8'd1, 0, 4'd0);
    idle(1, 4'd0);
    @(posedge clk); #2;
    checkOutput("short_pulse", 32'(err_short), 32'd1);
    checkOutput("short_valid", 32'(frame_valid), 32'd0);
    checkOutput("short_cnt", 32'(frame_cnt), 32'd0);
    idle(2, 4'd0);

    // Pixels 1..16 held; pixel at index 5 is 6.
    burst(16, 8'd1, 8'd1, 0, 4'd5);
    idle(2, 4'd5);
    @(posedge clk); #2;
    checkOutput("hold_valid", 32'(frame_valid), 32'd1);
    checkOutput("hold_sum", 32'(frame_sum), 32'd136);
    checkOutput("hold_max", 32'(frame_max), 32'd16);
    checkOutput("hold_rd5", 32'(rd_data), 32'd6);

    // Overrun burst of 0xFF while holding.
    burst(16, 8'hFF, 8'd0, 0, 4'd5);
    idle(2, 4'd5);
    @(posedge clk); #2;
    checkOutput("ovr_sum", 32'(frame_sum), 32'd136);
    checkOutput("ovr_cnt", 32'(frame_cnt), 32'd0);
    checkOutput("ovr_valid", 32'(frame_valid), 32'd1);

    // Release and restart in the same cycle: 0x20..0x2F.
    burst(16, 8'h20, 8'd1, 1, 4'd0);
    idle(2, 4'd0);
    @(posedge clk); #2;
    checkOutput("rs_cnt", 32'(frame_cnt), 32'd1);
    checkOutput("rs_rd0", 32'(rd_data), 32'h20);
    checkOutput("rs_sum", 32'(frame_sum), 32'd632);
    checkOutput("rs_max", 32'(frame_max), 32'h2F);

    applyStimulus(0, 0, 8'h00, 1, 4'd0);
    idle(1, 4'd0);
    @(posedge clk); #2;
    checkOutput("rel_valid", 32'(frame_valid), 32'd0);
    checkOutput("rel_cnt", 32'(frame_cnt), 32'd2);

    // Full-scale frame, then 256 releases: count returns to 2.
    burst(16, 8'hFF, 8'd0, 0, 4'd3);
    idle(1, 4'd3);
    @(posedge clk); #2;
    checkOutput("full_sum", 32'(frame_sum), 32'd4080);
    checkOutput("full_max", 32'(frame_max), 32'd255);
    for (int k = 0; k < 256; k++) begin
      if (k < 255) burst(16, 8'(k), 8'd3, 1, 4'(k));
      else         applyStimulus(0, 0, 8'h00, 1, 4'd0);
    end
    idle(1, 4'd0);
    @(posedge clk); #2;
    checkOutput("wrap_cnt", 32'(frame_cnt), 32'd2);
    checkOutput("wrap_valid", 32'(frame_valid), 32'd0);

    // Reset mid-burst, then a new frame 3..18 straight after.
    burst(8, 8'd9, 8'd1, 0, 4'd0);
    applyStimulus(1, 0, 8'h00, 0, 4'd0);
    burst(16, 8'd3, 8'd1, 0, 4'd15);
    idle(2, 4'd15);
    @(posedge clk); #2;
    checkOutput("rst_sum", 32'(frame_sum), 32'd168);
    checkOutput("rst_max", 32'(frame_max), 32'd18);
    checkOutput("rst_valid", 32'(frame_valid), 32'd1);
    checkOutput("rst_cnt", 32'(frame_cnt), 32'd0);

    // Release during a dropped burst must not start a frame.
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 8'h77, i == 2, 4'd0);
    idle(2, 4'd0);
    @(posedge clk); #2;
    checkOutput("drel_valid", 32'(frame_valid), 32'd0);
    checkOutput("drel_cnt", 32'(frame_cnt), 32'd1);
    burst(16, 8'h40, 8'd1, 0, 4'd0);
    idle(2, 4'd0);
    @(posedge clk); #2;
    checkOutput("after_sum", 32'(frame_sum), 32'd1144);
    checkOutput("after_max", 32'(frame_max), 32'h4F);
    checkOutput("after_rd0", 32'(rd_data), 32'h40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
